// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester RAM port arbiter.
package mem_arb_pkg;

  localparam int MEM_DEPTH_DEF  = 8192;
  localparam int STARVE_MAX_DEF = 3;
  localparam int DATA_W         = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_e;

  // Full-width range check so aliased high addresses are never accepted.
  function automatic logic addr_in_range(input logic [DATA_W-1:0] addr,
                                         input logic [DATA_W-1:0] depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// DM-priority grant decision with a bounded starvation counter for IF.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic dm_req,
  input  logic idle,
  output logic grant_if,
  output logic grant_dm
);

  logic [3:0] starve_r;
  logic       force_if_s;

  // Grant decision: DM wins unless IF has lost STARVE_MAX times in a row.
  always_comb begin
    force_if_s = (starve_r == 4'(STARVE_MAX));
    grant_dm   = idle & dm_req & ~(if_req & force_if_s);
    grant_if   = idle & if_req & ~grant_dm;
  end

  // Starvation counter: counts DM wins over a waiting IF, cleared by an IF grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_r <= 4'd0;
    end else if (grant_if) begin
      starve_r <= 4'd0;
    end else if (grant_dm && if_req && !force_if_s) begin
      starve_r <= starve_r + 4'd1;
    end else begin
      starve_r <= starve_r;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and the memory stage.
// Optional wait-cycle counters are enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter int RAM_AW     = 13,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [DATA_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_dm_wait
`endif
);

  localparam logic [2:0] LAT_LAST = 3'(RAM_LAT - 1);

  arb_state_e        state_r, state_nxt_s;
  req_id_e           id_r;
  logic              we_r, err_r;
  logic [RAM_AW-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r, rdata_r, addr_sel_s;
  logic [2:0]        lat_cnt_r;
  logic              grant_if_s, grant_dm_s, grant_any_s, range_ok_s, idle_s;

  assign idle_s = (state_r == IDLE);
  assign if_gnt = grant_if_s;
  assign dm_gnt = grant_dm_s;

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .dm_req   (dm_req),
    .idle     (idle_s),
    .grant_if (grant_if_s),
    .grant_dm (grant_dm_s)
  );

  // Command select and range check for the requester being granted.
  always_comb begin
    grant_any_s = grant_if_s | grant_dm_s;
    if (grant_dm_s) begin
      addr_sel_s = dm_addr;
    end else begin
      addr_sel_s = if_addr;
    end
    range_ok_s = addr_in_range(addr_sel_s, 64'(MEM_DEPTH));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: out-of-range commands skip the RAM and respond immediately.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_any_s) begin
          state_nxt_s = range_ok_s ? ISSUE : RESP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: state_nxt_s = WAIT;
      WAIT: begin
        if (lat_cnt_r == LAT_LAST) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Latched command, RAM latency counter and captured read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_r      <= REQ_IF;
      we_r      <= 1'b0;
      err_r     <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= 64'h0;
      rdata_r   <= 64'h0;
      lat_cnt_r <= 3'd0;
    end else begin
      if (idle_s && grant_any_s) begin
        id_r    <= grant_dm_s ? REQ_DM : REQ_IF;
        we_r    <= grant_dm_s & dm_we;
        err_r   <= ~range_ok_s;
        addr_r  <= addr_sel_s[RAM_AW-1:0];
        wdata_r <= grant_dm_s ? dm_wdata : 64'h0;
        rdata_r <= 64'h0;
      end
      if (state_r == ISSUE) begin
        lat_cnt_r <= 3'd0;
      end else if (state_r == WAIT) begin
        lat_cnt_r <= lat_cnt_r + 3'd1;
      end
      if (state_r == WAIT && lat_cnt_r == LAT_LAST) begin
        rdata_r <= we_r ? 64'h0 : ram_rdata;
      end
    end
  end

  // Outputs decoded from registered state and command.
  always_comb begin
    ram_en    = (state_r == ISSUE);
    ram_we    = ram_en & we_r;
    ram_addr  = addr_r;
    ram_wdata = wdata_r;
    if_done   = (state_r == RESP) && (id_r == REQ_IF);
    dm_done   = (state_r == RESP) && (id_r == REQ_DM);
    if_rdata  = if_done ? rdata_r : 64'h0;
    dm_rdata  = dm_done ? rdata_r : 64'h0;
    if_err    = if_done & err_r;
    dm_err    = dm_done & err_r;
    busy      = !idle_s;
  end

`ifdef ARB_PERF_CNT_EN
  // Saturating counts of cycles spent requesting without a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_wait <= 32'd0;
      perf_dm_wait <= 32'd0;
    end else begin
      if (if_req && !grant_if_s && perf_if_wait != 32'hFFFF_FFFF) begin
        perf_if_wait <= perf_if_wait + 32'd1;
      end
      if (dm_req && !grant_dm_s && perf_dm_wait != 32'hFFFF_FFFF) begin
        perf_dm_wait <= perf_dm_wait + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a 1-cycle RAM model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we;
  logic [63:0] if_addr, dm_addr, dm_wdata;
  logic        if_gnt, if_done, if_err, dm_gnt, dm_done, dm_err;
  logic [63:0] if_rdata, dm_rdata, ram_wdata, ram_rdata;
  logic        ram_en, ram_we, busy;
  logic [12:0] ram_addr;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_wait, perf_dm_wait;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_wait(perf_if_wait), .perf_dm_wait(perf_dm_wait)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model; address 0x20 is preloaded with 0x1234 on the first edge.
  logic [63:0] mem [0:8191];
  bit loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      mem[13'h20] <= 64'h1234;
      loaded      <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  int          ram_en_cnt = 0, ram_en_cyc = 0, if_done_cnt = 0, dm_done_cnt = 0;
  logic        ram_we_l = 1'b0;
  logic [12:0] ram_addr_l = 13'd0;
  logic [63:0] ram_wdata_l = 64'h0;
  logic        clash = 1'b0;

  always @(negedge clk) begin
    if (ram_en) begin
      ram_en_cnt  <= ram_en_cnt + 1;
      ram_en_cyc  <= cyc;
      ram_we_l    <= ram_we;
      ram_addr_l  <= ram_addr;
      ram_wdata_l <= ram_wdata;
    end
    if (if_done) if_done_cnt <= if_done_cnt + 1;
    if (dm_done) dm_done_cnt <= dm_done_cnt + 1;
    if ((if_gnt | dm_gnt) & (if_done | dm_done)) clash <= 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete transaction: hold req until grant, then wait for done.
  task automatic xact(input bit is_dm, input logic we, input logic [63:0] addr,
                      input logic [63:0] wdata, output int gnt_c, output int lat,
                      output logic [63:0] rdata, output logic err);
    bit got;
    gnt_c = -1; lat = -1; rdata = 64'h0; err = 1'b0;
    @(posedge clk); #1;
    if (is_dm) begin
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (is_dm ? dm_gnt : if_gnt) begin
        got = 1'b1; gnt_c = cyc;
      end
    end
    @(posedge clk); #1;
    dm_req = 1'b0; if_req = 1'b0;
    chk("gnt_seen", 64'(got), 64'd1);
    if (got) begin
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        if (c > 0 || gnt_c + 1 != cyc || !(is_dm ? dm_done : if_done)) @(negedge clk);
        if (is_dm ? dm_done : if_done) begin
          got = 1'b1; lat = cyc - gnt_c;
          rdata = is_dm ? dm_rdata : if_rdata;
          err = is_dm ? dm_err : if_err;
        end
      end
      chk("done_seen", 64'(got), 64'd1);
    end
  endtask

  initial begin
    int g, l, base, ng, en_base;
    logic [63:0] rd;
    logic er;
    bit got;
    logic [7:0] order;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] pb_if, pb_dm;
`endif
    rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = 64'h0; dm_addr = 64'h0; dm_wdata = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", 64'({busy, if_gnt, if_done, if_err, dm_gnt, dm_done, dm_err, ram_en, ram_we}), 64'h0);
    chk("rst_data", if_rdata | dm_rdata | ram_wdata | 64'(ram_addr), 64'h0);
    rst_n = 1'b1;

    // DM write then read of 0x10
    xact(1'b1, 1'b1, 64'h10, 64'hDEADBEEF, g, l, rd, er);
    chk("wr_lat", 64'(l), 64'd3);
    chk("wr_ram_en_t", 64'(ram_en_cyc - g), 64'd1);
    chk("wr_ram_we", 64'(ram_we_l), 64'd1);
    chk("wr_ram_addr", 64'(ram_addr_l), 64'h10);
    chk("wr_ram_wdata", ram_wdata_l, 64'hDEADBEEF);
    chk("wr_err", 64'(er), 64'd0);
    chk("wr_rdata", rd, 64'h0);
    xact(1'b1, 1'b0, 64'h10, 64'h0, g, l, rd, er);
    chk("rd_lat", 64'(l), 64'd3);
    chk("rd_rdata", rd, 64'hDEADBEEF);
    chk("rd_err", 64'(er), 64'd0);
    chk("rd_ram_we", 64'(ram_we_l), 64'd0);

    // IF read of preloaded 0x20
    xact(1'b0, 1'b0, 64'h20, 64'h0, g, l, rd, er);
    chk("if_lat", 64'(l), 64'd3);
    chk("if_rdata", rd, 64'h1234);
    chk("if_err", 64'(er), 64'd0);

    // Both requesters held: expect DM,DM,DM,IF,DM,DM,DM,IF
    @(posedge clk); #1;
    base = dm_done_cnt; en_base = if_done_cnt;
    if_req = 1'b1; if_addr = 64'h20; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h10;
    ng = 0; order = 8'h0;
    for (int c = 0; c < 200 && ng < 8; c++) begin
      @(negedge clk);
      if (dm_gnt) begin
        order[ng] = 1'b0; ng++;
      end else if (if_gnt) begin
        order[ng] = 1'b1; ng++;
      end
    end
    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0;
    repeat (8) @(negedge clk);
    chk("starve_ngrants", 64'(ng), 64'd8);
    chk("starve_order", 64'(order), 64'h88);
    chk("starve_dm_dones", 64'(dm_done_cnt - base), 64'd6);
    chk("starve_if_dones", 64'(if_done_cnt - en_base), 64'd2);

    // Out-of-range DM read, then a normal IF read
    en_base = ram_en_cnt;
    xact(1'b1, 1'b0, 64'd8192, 64'h0, g, l, rd, er);
    chk("oor_lat", 64'(l), 64'd1);
    chk("oor_err", 64'(er), 64'd1);
    chk("oor_rdata", rd, 64'h0);
    repeat (2) @(negedge clk);
    chk("oor_no_ram_en", 64'(ram_en_cnt), 64'(en_base));
    xact(1'b0, 1'b0, 64'h20, 64'h0, g, l, rd, er);
    chk("oor_next_lat", 64'(l), 64'd3);
    chk("oor_next_rdata", rd, 64'h1234);

    // Reset during WAIT of a DM read
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h10;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (dm_gnt) got = 1'b1;
    end
    chk("rstw_gnt_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    dm_req = 1'b0;
    @(posedge clk); #1;
    chk("rstw_busy", 64'(busy), 64'd1);
    base = dm_done_cnt;
    rst_n = 1'b0;
    #1;
    chk("rstw_ctrl", 64'({busy, if_gnt, if_done, if_err, dm_gnt, dm_done, dm_err, ram_en, ram_we}), 64'h0);
    chk("rstw_data", if_rdata | dm_rdata | ram_wdata | 64'(ram_addr), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rstw_no_done", 64'(dm_done_cnt), 64'(base));
    xact(1'b0, 1'b0, 64'h20, 64'h0, g, l, rd, er);
    chk("rstw_if_lat", 64'(l), 64'd3);
    chk("rstw_if_rdata", rd, 64'h1234);

`ifdef ARB_PERF_CNT_EN
    // IF waits T+1..T+5 behind two DM transactions
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h40; dm_wdata = 64'h5;
    pb_if = perf_if_wait; pb_dm = perf_dm_wait;
    @(negedge clk); chk("perf_gnt1", 64'(dm_gnt), 64'd1);
    @(posedge clk); #1; dm_req = 1'b0; if_req = 1'b1; if_addr = 64'h20;
    @(posedge clk); #1;
    @(posedge clk); #1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'd8192;
    @(posedge clk); #1;
    @(negedge clk); chk("perf_gnt2", 64'(dm_gnt), 64'd1);
    @(posedge clk); #1; dm_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); chk("perf_gnt_if", 64'(if_gnt), 64'd1);
    @(posedge clk); #1; if_req = 1'b0;
    chk("perf_if_wait", 64'(perf_if_wait - pb_if), 64'd5);
    chk("perf_dm_wait", 64'(perf_dm_wait - pb_dm), 64'd1);
    repeat (6) @(negedge clk);
`endif

    chk("gnt_done_apart", 64'(clash), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
